tx_frame_scheduler: RTL and testbench

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

---
 rtl/tx_sched_pkg.sv | 15 +
 rtl/tx_rr_arbiter.sv | 40 ++++
 rtl/tx_frame_scheduler.sv | 149 ++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the TX frame scheduler.
// TX_STRICT_PRIORITY_EN (in tx_rr_arbiter) selects fixed priority instead of round-robin.
package tx_sched_pkg;

  localparam int unsigned IFG_CYCLES_DEF = 12;
  localparam int unsigned LEN_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-requester arbiter with one-hot grant; pointer advances on update_i.
// Define TX_STRICT_PRIORITY_EN to make requester 0 always win contention.
module tx_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

`ifdef TX_STRICT_PRIORITY_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, update_i};

  always_comb begin
    grant_o = '0;
    if (req_i[0])      grant_o = 2'b01;
    else if (req_i[1]) grant_o = 2'b10;
  end
`else
  // Set when requester 1 was served last; reset value favours requester 0.
  logic last1_q;

  always_comb begin
    grant_o = '0;
    if (req_i[0] && req_i[1]) grant_o = last1_q ? 2'b01 : 2'b10;
    else if (req_i[0])        grant_o = 2'b01;
    else if (req_i[1])        grant_o = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last1_q <= 1'b1;
    end else if (update_i && (grant_o != '0)) begin
      last1_q <= grant_o[1];
    end
  end
`endif

endmodule

// File: rtl/tx_frame_scheduler.sv
// Arbitrates two frame requesters onto one MAC and enforces an inter-frame gap.
// Build option TX_STRICT_PRIORITY_EN: requester 0 always wins contention.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [31:0]      wdata0,
  input  logic [31:0]      wdata1,
  output logic             rd0,
  output logic             rd1,
  output logic [1:0]       grant,
  output logic [1:0]       frame_done,
  output logic [31:0]      mac_data,
  output logic             mac_tx_en,
  input  logic             mac_data_en,
  input  logic             mac_tx_done,
  output logic             busy
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  tx_state_e        state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             tx_en_q, tx_en_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [1:0]       arb_gnt;
  logic             arb_update;
  logic [LEN_W-1:0] win_len;
  logic             go_gap;
  logic             pop;

  tx_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1, req0}),
    .update_i (arb_update),
    .grant_o  (arb_gnt)
  );

  assign win_len = arb_gnt[1] ? len1 : len0;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    tx_en_d    = tx_en_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    arb_update = 1'b0;
    go_gap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          arb_update = 1'b1;
          if (win_len == '0) begin
            done_d = arb_gnt;
            go_gap = 1'b1;
          end else begin
            grant_d = arb_gnt;
            cnt_d   = win_len;
            tx_en_d = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // An abort from the MAC wins over a simultaneous word accept.
        if (mac_tx_done) begin
          done_d  = grant_q;
          grant_d = '0;
          tx_en_d = 1'b0;
          cnt_d   = '0;
          go_gap  = 1'b1;
        end else if (mac_data_en) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            tx_en_d = 1'b0;
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (mac_tx_done) begin
          done_d  = grant_q;
          grant_d = '0;
          go_gap  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_gap) begin
      if (IFG_CYCLES == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_GAP;
        gap_d   = GAP_W'(IFG_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      tx_en_q <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      tx_en_q <= tx_en_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign pop        = (state_q == ST_SEND) && mac_data_en && !mac_tx_done;
  assign rd0        = pop && grant_q[0];
  assign rd1        = pop && grant_q[1];
  assign mac_data   = (state_q == ST_SEND) ? (grant_q[1] ? wdata1 : wdata0) : '0;
  assign grant      = grant_q;
  assign frame_done = done_q;
  assign mac_tx_en  = tx_en_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler (IFG 12, LEN_W 8).
// Expectations follow TX_STRICT_PRIORITY_EN when that macro is defined.
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  len0, len1;
  logic [31:0] wdata0, wdata1;
  logic        rd0, rd1;
  logic [1:0]  grant, frame_done;
  logic [31:0] mac_data;
  logic        mac_tx_en, mac_data_en, mac_tx_done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_frame_scheduler #(.IFG_CYCLES(12), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1), .rd0(rd0), .rd1(rd1),
    .grant(grant), .frame_done(frame_done), .mac_data(mac_data),
    .mac_tx_en(mac_tx_en), .mac_data_en(mac_data_en),
    .mac_tx_done(mac_tx_done), .busy(busy)
  );

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
    wdata0 = 0; wdata1 = 0; mac_data_en = 0; mac_tx_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1; req1 = 1; len0 = 8'd5; len1 = 8'd5;
    wdata0 = 32'hFFFF_FFFF; wdata1 = 32'hFFFF_FFFF; mac_data_en = 1; mac_tx_done = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, frame_done, rd0, rd1, mac_tx_en, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {grant, frame_done, rd0, rd1, mac_tx_en, busy});
    end
    checks++;
    if (mac_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h want 00000000", mac_data);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [31:0] words [3];
    words[0] = 32'hDEADBEEF; words[1] = 32'h01234567; words[2] = 32'h89ABCDEF;
    apply_reset();
    req0 = 1; len0 = 8'd3; wdata0 = words[0];
    @(negedge clk);
    checks++;
    if ({grant, mac_tx_en, busy} !== 4'b0111) begin
      errors++; $display("FAIL single_grant got %b want 0111", {grant, mac_tx_en, busy});
    end
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      mac_data_en = 1; #1;
      checks++;
      if ({rd0, rd1} !== 2'b10 || mac_data !== words[i]) begin
        errors++;
        $display("FAIL single_word%0d got rd=%b data=%h want rd=10 data=%h", i, {rd0, rd1}, mac_data, words[i]);
      end
      @(negedge clk);
      mac_data_en = 0;
      if (i < 2) wdata0 = words[i+1];
      checks++;
      if (mac_tx_en !== (i < 2)) begin
        errors++; $display("FAIL single_txen%0d got %b want %b", i, mac_tx_en, (i < 2));
      end
    end
    mac_data_en = 1; #1;
    checks++;
    if (rd0 !== 1'b0) begin errors++; $display("FAIL single_rd_wait got %b want 0", rd0); end
    @(negedge clk);
    mac_data_en = 0;
    checks++;
    if ({grant, frame_done} !== 4'b0100) begin
      errors++; $display("FAIL single_wait got %b want 0100", {grant, frame_done});
    end
    mac_tx_done = 1;
    @(negedge clk);
    mac_tx_done = 0; req0 = 0;
    checks++;
    if ({frame_done, grant, busy} !== 5'b01001) begin
      errors++; $display("FAIL single_done got %b want 01001", {frame_done, grant, busy});
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 2'b00) begin errors++; $display("FAIL single_done_pulse got %b want 00", frame_done); end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_end got %b want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
  endtask

  task automatic test_contention();
    logic [1:0] exp2;
`ifdef TX_STRICT_PRIORITY_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    apply_reset();
    req0 = 1; req1 = 1; len0 = 8'd2; len1 = 8'd2;
    wdata0 = 32'hA0A0_0001; wdata1 = 32'hB1B1_0001;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL cont_first got %b want 01", grant); end
    mac_data_en = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({rd0, rd1} !== 2'b10 || mac_data !== 32'hA0A0_0001) begin
        errors++; $display("FAIL cont_pop%0d got rd=%b data=%h want rd=10 data=a0a00001", i, {rd0, rd1}, mac_data);
      end
      @(negedge clk);
    end
    mac_data_en = 0;
    checks++;
    if (mac_tx_en !== 1'b0) begin errors++; $display("FAIL cont_txen got %b want 0", mac_tx_en); end
    mac_tx_done = 1;
    @(negedge clk);
    mac_tx_done = 0;
    checks++;
    if ({frame_done, grant} !== 4'b0100) begin
      errors++; $display("FAIL cont_done got %b want 0100", {frame_done, grant});
    end
    repeat (11) @(negedge clk);
    checks++;
    if ({busy, grant} !== 3'b100) begin errors++; $display("FAIL cont_gap12 got %b want 100", {busy, grant}); end
    @(negedge clk);
    checks++;
    if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL cont_idle got %b want 000", {busy, grant}); end
    @(negedge clk);
    checks++;
    if (grant !== exp2) begin errors++; $display("FAIL cont_second got %b want %b", grant, exp2); end
    req0 = 0; req1 = 0;
  endtask

  task automatic serve_frame(input int unsigned n, output logic [1:0] g);
    int unsigned t = 0;
    while (grant == 2'b00 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (grant == 2'b00) begin errors++; $display("FAIL serve_timeout got grant %b want nonzero", grant); end
    g = grant;
    mac_data_en = 1;
    repeat (n) @(negedge clk);
    mac_data_en = 0;
    mac_tx_done = 1;
    @(negedge clk);
    mac_tx_done = 0;
  endtask

  task automatic test_fairness();
    logic [1:0] g;
    logic [1:0] exp [4];
`ifdef TX_STRICT_PRIORITY_EN
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b01;
`else
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
`endif
    apply_reset();
    req0 = 1; req1 = 1; len0 = 8'd1; len1 = 8'd1;
    for (int f = 0; f < 4; f++) begin
      serve_frame(1, g);
      checks++;
      if (g !== exp[f]) begin errors++; $display("FAIL fair_frame%0d got %b want %b", f, g, exp[f]); end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_zero_len();
    logic seen;
    apply_reset();
    req1 = 1; len1 = 8'd0; mac_data_en = 1;
    @(negedge clk);
    req1 = 0;
    checks++;
    if ({frame_done, grant, rd1, mac_tx_en, busy} !== 7'b1000001) begin
      errors++; $display("FAIL zero_done got %b want 1000001", {frame_done, grant, rd1, mac_tx_en, busy});
    end
    seen = 1'b0;
    repeat (13) begin
      @(negedge clk);
      seen = seen | mac_tx_en | rd1 | rd0 | (frame_done != 2'b00);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL zero_quiet got %b want 0", seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle got %b want 0", busy); end
    mac_data_en = 0;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    req0 = 1; len0 = 8'd4; wdata0 = 32'h1111_0000;
    @(negedge clk);
    mac_data_en = 1;
    @(negedge clk);
    mac_data_en = 0; rst_n = 0;
    @(negedge clk);
    checks++;
    if ({grant, frame_done, rd0, rd1, mac_tx_en, busy} !== 8'h00 || mac_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outs got %b/%h want 00000000/00000000", {grant, frame_done, rd0, rd1, mac_tx_en, busy}, mac_data);
    end
    rst_n = 1; len0 = 8'd1; wdata0 = 32'h2222_0000;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || mac_data !== 32'h2222_0000) begin
      errors++; $display("FAIL midrst_regrant got %b/%h want 01/22220000", grant, mac_data);
    end
    mac_data_en = 1; #1;
    checks++;
    if (rd0 !== 1'b1) begin errors++; $display("FAIL midrst_rd got %b want 1", rd0); end
    @(negedge clk);
    mac_data_en = 0; mac_tx_done = 1;
    @(negedge clk);
    mac_tx_done = 0; req0 = 0;
    checks++;
    if (frame_done !== 2'b01) begin errors++; $display("FAIL midrst_done got %b want 01", frame_done); end
  endtask

  task automatic test_early_abort();
    apply_reset();
    req0 = 1; len0 = 8'd4; wdata0 = 32'hCAFE_0000;
    @(negedge clk);
    mac_data_en = 1;
    repeat (2) @(negedge clk);
    mac_data_en = 0;
    checks++;
    if (mac_tx_en !== 1'b1) begin errors++; $display("FAIL abort_txen got %b want 1", mac_tx_en); end
    mac_tx_done = 1; mac_data_en = 1; #1;
    checks++;
    if (rd0 !== 1'b0) begin errors++; $display("FAIL abort_rd_same got %b want 0", rd0); end
    @(negedge clk);
    mac_tx_done = 0; req0 = 0;
    checks++;
    if ({frame_done, grant, mac_tx_en, busy} !== 6'b010001) begin
      errors++; $display("FAIL abort_done got %b want 010001", {frame_done, grant, mac_tx_en, busy});
    end
    #1;
    checks++;
    if (rd0 !== 1'b0) begin errors++; $display("FAIL abort_rd_gap got %b want 0", rd0); end
    @(negedge clk);
    mac_data_en = 0;
    checks++;
    if (frame_done !== 2'b00) begin errors++; $display("FAIL abort_pulse got %b want 00", frame_done); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_fairness();
    test_zero_len();
    test_reset_mid_frame();
    test_early_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
